// File: rtl/control_seq_unit_if.sv
// Instruction-memory fetch handshake between control_seq_unit (master) and imem (slave).
interface control_seq_unit_if #(
    parameter int BITS   = 16,
    parameter int DTBITS = 11
);
    logic [BITS-1:0]   i_Data;
    logic              i_valid;
    logic              o_fetch;
    logic [DTBITS-1:0] o_Addr;

    modport master (input i_Data, i_valid, output o_fetch, o_Addr);
    modport slave  (output i_Data, i_valid, input o_fetch, o_Addr);
endinterface

// File: rtl/control_seq_unit.sv
// Multi-cycle accumulator-CPU control unit: FETCH -> EXEC sequencing, opcode decode to datapath strobes.
// Optional return stack enabled by defining CALL_STACK_EN.
module control_seq_unit #(
    parameter int BITS        = 16,
    parameter int OPBITS      = 5,
    parameter int DTBITS      = BITS - OPBITS,
    parameter int STACK_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    control_seq_unit_if.master imem,
    input  logic               i_acc_zero,
    output logic [DTBITS-1:0]  o_Data,
    output logic [1:0]         sel_A,
    output logic               sel_B,
    output logic               o_op,
    output logic               w_acc,
    output logic               w_ram,
    output logic               r_ram,
    output logic               h_flg,
    output logic               o_err
);
    typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_EXEC = 2'd1, ST_HALT = 2'd2} state_t;

    localparam logic [OPBITS-1:0] OP_HLT  = OPBITS'(0);
    localparam logic [OPBITS-1:0] OP_STO  = OPBITS'(1);
    localparam logic [OPBITS-1:0] OP_LD   = OPBITS'(2);
    localparam logic [OPBITS-1:0] OP_LDI  = OPBITS'(3);
    localparam logic [OPBITS-1:0] OP_ADD  = OPBITS'(4);
    localparam logic [OPBITS-1:0] OP_ADDI = OPBITS'(5);
    localparam logic [OPBITS-1:0] OP_SUB  = OPBITS'(6);
    localparam logic [OPBITS-1:0] OP_SUBI = OPBITS'(7);
    localparam logic [OPBITS-1:0] OP_JMP  = OPBITS'(8);
    localparam logic [OPBITS-1:0] OP_BEQ  = OPBITS'(9);
    localparam logic [OPBITS-1:0] OP_BNE  = OPBITS'(10);

    state_t              r_state, w_nstate;
    logic [DTBITS-1:0]   r_pc, w_npc, w_pc_inc, w_opnd;
    logic [BITS-1:0]     r_ir;
    logic [OPBITS-1:0]   w_opc;
    logic                r_err, w_err_set, w_fetch;

`ifdef CALL_STACK_EN
    localparam logic [OPBITS-1:0] OP_CALL = OPBITS'(11);
    localparam logic [OPBITS-1:0] OP_RET  = OPBITS'(12);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DTBITS-1:0] r_stack [STACK_DEPTH];
    logic [SPW-1:0]    r_sp;
    logic [IW-1:0]     w_wr_idx, w_rd_idx;
    logic              w_push, w_pop;

    assign w_wr_idx = IW'(r_sp);
    assign w_rd_idx = IW'(r_sp - 1'b1);
`endif

    assign w_opc        = r_ir[BITS-1 -: OPBITS];
    assign w_opnd       = r_ir[DTBITS-1:0];
    assign w_pc_inc     = r_pc + 1'b1;
    assign o_Data       = w_opnd;
    assign o_err        = r_err;
    assign imem.o_Addr  = r_pc;
    assign imem.o_fetch = w_fetch;

    always_comb begin
        w_nstate  = r_state;
        w_npc     = r_pc;
        w_err_set = 1'b0;
        w_fetch   = 1'b0;
        sel_A     = 2'd0;
        sel_B     = 1'b0;
        o_op      = 1'b0;
        w_acc     = 1'b0;
        w_ram     = 1'b0;
        r_ram     = 1'b0;
        h_flg     = 1'b0;
`ifdef CALL_STACK_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
`endif
        unique case (r_state)
            ST_FETCH: begin
                w_fetch = 1'b1;
                if (imem.i_valid) w_nstate = ST_EXEC;
            end
            ST_EXEC: begin
                w_nstate = ST_FETCH;
                w_npc    = w_pc_inc;
                case (w_opc)
                    OP_HLT:  begin w_nstate = ST_HALT; w_npc = r_pc; end
                    OP_STO:  w_ram = 1'b1;
                    OP_LD:   begin r_ram = 1'b1; w_acc = 1'b1; end
                    OP_LDI:  begin sel_A = 2'd1; w_acc = 1'b1; end
                    OP_ADD:  begin r_ram = 1'b1; sel_A = 2'd2; w_acc = 1'b1; end
                    OP_ADDI: begin sel_A = 2'd2; sel_B = 1'b1; w_acc = 1'b1; end
                    OP_SUB:  begin r_ram = 1'b1; sel_A = 2'd2; o_op = 1'b1; w_acc = 1'b1; end
                    OP_SUBI: begin sel_A = 2'd2; sel_B = 1'b1; o_op = 1'b1; w_acc = 1'b1; end
                    OP_JMP:  w_npc = w_opnd;
                    OP_BEQ:  if (i_acc_zero)  w_npc = w_opnd;
                    OP_BNE:  if (!i_acc_zero) w_npc = w_opnd;
`ifdef CALL_STACK_EN
                    // Stack faults are fatal: halt with PC left on the faulting instruction.
                    OP_CALL: begin
                        if (r_sp == SPW'(STACK_DEPTH)) begin
                            w_err_set = 1'b1; w_nstate = ST_HALT; w_npc = r_pc;
                        end else begin
                            w_push = 1'b1; w_npc = w_opnd;
                        end
                    end
                    OP_RET: begin
                        if (r_sp == '0) begin
                            w_err_set = 1'b1; w_nstate = ST_HALT; w_npc = r_pc;
                        end else begin
                            w_pop = 1'b1; w_npc = r_stack[w_rd_idx];
                        end
                    end
`endif
                    default: w_err_set = 1'b1;
                endcase
            end
            ST_HALT: h_flg = 1'b1;
            default: w_nstate = ST_FETCH;
        endcase
        if (i_rst) begin
            sel_A = 2'd0; sel_B = 1'b0; o_op  = 1'b0;
            w_acc = 1'b0; w_ram = 1'b0; r_ram = 1'b0; h_flg = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_pc    <= w_npc;
            if (r_state == ST_FETCH && imem.i_valid) r_ir <= imem.i_Data;
            if (w_err_set) r_err <= 1'b1;
        end
    end

`ifdef CALL_STACK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp <= '0;
        end else if (w_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
            r_sp              <= r_sp + 1'b1;
        end else if (w_pop) begin
            r_sp <= r_sp - 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_control_seq_unit.sv
// Self-checking bench for control_seq_unit: ISA-level reference model, directed and random programs.
module tb_control_seq_unit;
    localparam int BITS = 16, OPBITS = 5, DTBITS = 11, DEPTH = 4;

    logic              i_clk = 1'b0;
    logic              i_rst, i_acc_zero;
    logic [DTBITS-1:0] o_Data;
    logic [1:0]        sel_A;
    logic              sel_B, o_op, w_acc, w_ram, r_ram, h_flg, o_err;
    logic [6:0]        w_strb;

    control_seq_unit_if #(.BITS(BITS), .DTBITS(DTBITS)) bus ();

    control_seq_unit #(.BITS(BITS), .OPBITS(OPBITS), .STACK_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .imem(bus), .i_acc_zero(i_acc_zero),
        .o_Data(o_Data), .sel_A(sel_A), .sel_B(sel_B), .o_op(o_op), .w_acc(w_acc),
        .w_ram(w_ram), .r_ram(r_ram), .h_flg(h_flg), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;
    assign w_strb = {sel_A, sel_B, o_op, w_acc, w_ram, r_ram};

    int n_checks = 0, n_errors = 0;

    // Architectural model state
    logic [DTBITS-1:0] m_pc;
    bit                m_err, m_halt;
    logic [DTBITS-1:0] m_stk[$];

    function automatic logic [15:0] mk(input int opc, input int opnd);
        logic [4:0]  o = opc[4:0];
        logic [10:0] d = opnd[10:0];
        return {o, d};
    endfunction

    // {sel_A, sel_B, o_op, w_acc, w_ram, r_ram} per mnemonic
    function automatic logic [6:0] exp_strobes(input logic [4:0] opc);
        case (opc)
            5'd1:    return 7'b00_0_0_010; // STO
            5'd2:    return 7'b00_0_0_101; // LD
            5'd3:    return 7'b01_0_0_100; // LDI
            5'd4:    return 7'b10_0_0_101; // ADD
            5'd5:    return 7'b10_1_0_100; // ADDI
            5'd6:    return 7'b10_0_1_101; // SUB
            5'd7:    return 7'b10_1_1_100; // SUBI
            default: return 7'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = '0; m_err = 0; m_halt = 0; m_stk.delete();
    endtask

    task automatic model_exec(input logic [15:0] ins, input logic az);
        int opc  = int'(ins[15:11]);
        logic [DTBITS-1:0] opnd = ins[10:0];
        logic [DTBITS-1:0] nxt  = m_pc + 11'd1;
        if (opc == 0)                     m_halt = 1;
        else if (opc >= 1 && opc <= 7)    m_pc = nxt;
        else if (opc == 8)                m_pc = opnd;
        else if (opc == 9)                m_pc = az ? opnd : nxt;
        else if (opc == 10)               m_pc = az ? nxt : opnd;
`ifdef CALL_STACK_EN
        else if (opc == 11) begin
            if (m_stk.size() == DEPTH) begin m_err = 1; m_halt = 1; end
            else begin m_stk.push_back(nxt); m_pc = opnd; end
        end else if (opc == 12) begin
            if (m_stk.size() == 0) begin m_err = 1; m_halt = 1; end
            else m_pc = m_stk.pop_back();
        end
`endif
        else begin m_err = 1; m_pc = nxt; end
    endtask

    // Drives one instruction through FETCH (with optional stall) and EXEC, checking both.
    task automatic run_instr(input logic [15:0] ins, input logic az, input int waits);
        logic [6:0] es;
        if (o_fetch_chk(1'b1) !== 1'b1) begin
            $display("FAIL fetch_req: o_fetch=%b required 1", bus.o_fetch); n_errors++;
        end
        n_checks++;
        if (bus.o_Addr !== m_pc) begin
            $display("FAIL fetch_addr: o_Addr=%h required %h", bus.o_Addr, m_pc); n_errors++;
        end
        n_checks++;
        for (int k = 0; k < waits; k++) begin
            bus.i_valid = 1'b0; bus.i_Data = 16'($urandom);
            @(negedge i_clk);
            if (bus.o_fetch !== 1'b1 || bus.o_Addr !== m_pc || w_strb !== 7'b0) begin
                $display("FAIL stall: fetch=%b addr=%h strb=%b required 1 %h 0", bus.o_fetch, bus.o_Addr, w_strb, m_pc);
                n_errors++;
            end
            n_checks++;
        end
        bus.i_valid = 1'b1; bus.i_Data = ins; i_acc_zero = az;
        @(negedge i_clk);
        bus.i_valid = 1'($urandom); bus.i_Data = 16'($urandom);
        es = exp_strobes(ins[15:11]);
        if (w_strb !== es) begin
            $display("FAIL exec_strobes ins=%h: strb=%b required %b", ins, w_strb, es); n_errors++;
        end
        n_checks++;
        if (o_Data !== ins[10:0] || bus.o_fetch !== 1'b0) begin
            $display("FAIL exec_data ins=%h: o_Data=%h fetch=%b required %h 0", ins, o_Data, bus.o_fetch, ins[10:0]);
            n_errors++;
        end
        n_checks++;
        model_exec(ins, az);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        if (bus.o_Addr !== m_pc || o_err !== m_err || h_flg !== m_halt || bus.o_fetch !== !m_halt) begin
            $display("FAIL next_state ins=%h: addr=%h err=%b h=%b fetch=%b required %h %b %b %b",
                     ins, bus.o_Addr, o_err, h_flg, bus.o_fetch, m_pc, m_err, m_halt, !m_halt);
            n_errors++;
        end
        n_checks++;
    endtask

    function automatic logic o_fetch_chk(input logic dummy);
        return bus.o_fetch & dummy;
    endfunction

    task automatic test_reset();
        i_rst = 1'b1; bus.i_valid = 1'b1; bus.i_Data = mk(3, 5); i_acc_zero = 1'b0;
        @(negedge i_clk); @(negedge i_clk);
        if (h_flg !== 1'b0 || w_strb !== 7'b0 || bus.o_fetch !== 1'b1 || bus.o_Addr !== 11'd0) begin
            $display("FAIL reset_hold: h=%b strb=%b fetch=%b addr=%h required 0 0 1 0", h_flg, w_strb, bus.o_fetch, bus.o_Addr);
            n_errors++;
        end
        n_checks++;
        i_rst = 1'b0; bus.i_valid = 1'b0;
        model_reset();
        if (o_err !== 1'b0) begin
            $display("FAIL reset_err: o_err=%b required 0", o_err); n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_ldi();
        run_instr(mk(3, 5), 1'b0, 0);
    endtask

    task automatic test_fetch_wait();
        run_instr(mk(4, 11'h23), 1'b0, 3);
    endtask

    task automatic test_branch();
        run_instr(mk(9, 11'h40), 1'b1, 0);   // BEQ taken -> 0x40
        run_instr(mk(9, 11'h10), 1'b0, 0);   // BEQ not taken -> 0x41
        run_instr(mk(10, 11'h10), 1'b1, 1);  // BNE not taken -> 0x42
        run_instr(mk(10, 11'h41), 1'b0, 0);  // BNE taken -> 0x41
        run_instr(mk(10, 11'h41), 1'b0, 0);  // tight loop on itself
    endtask

    task automatic test_wrap();
        run_instr(mk(8, 11'h7FF), 1'b0, 0);
        run_instr(mk(5, 11'h003), 1'b0, 0);  // PC wraps to 0
        run_instr(mk(31, 11'h155), 1'b0, 0); // illegal -> o_err, PC+1
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int opc = (($urandom % 8) == 0) ? int'($urandom_range(13, 31)) : int'($urandom_range(1, 10));
            run_instr(mk(opc, int'($urandom)), 1'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_halt();
        logic [DTBITS-1:0] frozen;
        run_instr(mk(31, 0), 1'b0, 0);  // set o_err so reset must clear it
        run_instr(mk(0, 11'h3A), 1'b0, 0);
        frozen = m_pc;
        for (int k = 0; k < 5; k++) begin
            bus.i_valid = 1'b1; bus.i_Data = mk(3, 7);
            @(negedge i_clk);
            if (h_flg !== 1'b1 || bus.o_fetch !== 1'b0 || w_strb !== 7'b0 || bus.o_Addr !== frozen || o_err !== 1'b1) begin
                $display("FAIL halted: h=%b fetch=%b strb=%b addr=%h err=%b required 1 0 0 %h 1",
                         h_flg, bus.o_fetch, w_strb, bus.o_Addr, o_err, frozen);
                n_errors++;
            end
            n_checks++;
        end
        bus.i_valid = 1'b0;
        i_rst = 1'b1; @(negedge i_clk); i_rst = 1'b0;
        model_reset();
        if (h_flg !== 1'b0 || bus.o_Addr !== 11'd0 || o_err !== 1'b0 || bus.o_fetch !== 1'b1) begin
            $display("FAIL halt_reset: h=%b addr=%h err=%b fetch=%b required 0 0 0 1", h_flg, bus.o_Addr, o_err, bus.o_fetch);
            n_errors++;
        end
        n_checks++;
        run_instr(mk(3, 9), 1'b0, 0);
    endtask

    task automatic test_call_stack();
        i_rst = 1'b1; @(negedge i_clk); i_rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) run_instr(mk(3, k), 1'b0, 0);
        run_instr(mk(11, 11'h10), 1'b0, 0);  // CALL at 0x03; on a stackless build this is illegal
        run_instr(mk(12, 0), 1'b0, 0);       // RET
`ifdef CALL_STACK_EN
        for (int k = 0; k < 5; k++) run_instr(mk(11, 11'h20 + k), 1'b0, 0);
        if (h_flg !== 1'b1 || o_err !== 1'b1) begin
            $display("FAIL stack_overflow: h=%b err=%b required 1 1", h_flg, o_err); n_errors++;
        end
        n_checks++;
        i_rst = 1'b1; @(negedge i_clk); i_rst = 1'b0;
        model_reset();
        run_instr(mk(12, 0), 1'b0, 0);       // RET on empty stack -> halt
`endif
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_Data = '0; i_acc_zero = 1'b0; i_rst = 1'b1;
        model_reset();
        test_reset();
        test_ldi();
        test_fetch_wait();
        test_branch();
        test_wrap();
        test_random();
        test_halt();
        test_call_stack();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
